trig_capture_adr_gen: RTL and testbench
=======================================

# trig_capture_adr_gen

Parametrised write-address generator for a triggered sample-capture RAM, with a programmable pre-trigger window over a circular buffer. It sits between the trigger-detect logic and the capture RAM write port, and hands the read side the address of the oldest captured sample. It supports single-shot and auto-re-arm capture modes, and completes each capture with a handshake from the reader.

## Interface
- DEPTH, 640, number of RAM words; 2 <= DEPTH <= 2^ADR_W
- ADR_W, 10, address and counter width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  start a capture; honoured only in IDLE
- trig  in  1  trigger request (level); sampled only in ARMED
- mode  in  1  0 = single-shot (DONE->IDLE), 1 = auto-re-arm (DONE->PRE)
- pre_len  in  ADR_W  pre-trigger sample count; captured at arm
- rd_ack  in  1  reader finished the buffer; honoured only in DONE
- wren  out  1  RAM write enable
- wr_adr  out  ADR_W  RAM write address
- rst_trig  out  1  one-cycle pulse that clears the upstream trigger latch
- trig_adr  out  ADR_W  address holding the trigger sample
- start_adr  out  ADR_W  address of the oldest valid sample, (trig_adr - pre_len) mod DEPTH
- busy  out  1  state is PRE, ARMED or POST
- done  out  1  state is DONE

## Operation
- States: IDLE, PRE, ARMED, POST, DONE. The reset state is IDLE.
- wren = 1 in PRE, ARMED and POST; otherwise 0. wren is decoded from state only.
- In every wren cycle, the sample is written at wr_adr, then wr_adr advances: DEPTH-1 wraps to 0. Wrap is explicit, not a power-of-two overflow.
- pre_len_q is latched from pre_len on arm. If pre_len > DEPTH-1, pre_len_q = DEPTH-1.
- IDLE + arm: wr_adr <- 0 and pre_cnt <- 0.
  - Next state is PRE, or ARMED if pre_len_q = 0.
  - A trig in the same cycle is ignored.
- PRE: pre_cnt increments per write. The write with pre_cnt = pre_len_q-1 moves the FSM to ARMED. trig is ignored throughout PRE.
- ARMED: writes continue circularly, overwriting older data. When trig = 1:
  - The current write is the trigger sample; trig_adr <- wr_adr.
  - post_cnt <- DEPTH - pre_len_q - 1.
  - Next state is POST, or DONE if that value is 0.
- POST: post_cnt decrements per write. The write with post_cnt = 1 moves the FSM to DONE.
- Each capture therefore holds exactly DEPTH samples: pre_len_q before the trigger, the trigger sample, then DEPTH - pre_len_q - 1 after it.
- start_adr is updated together with trig_adr. It must equal wr_adr on entry to DONE.
- DONE + rd_ack, mode = 0: go to IDLE.
- DONE + rd_ack, mode = 1: same actions as IDLE + arm, with pre_len re-latched; go to PRE, or ARMED if pre_len = 0.
- arm is ignored outside IDLE. rd_ack is ignored outside DONE.
- trig_adr and start_adr hold their values until the next trigger acceptance.

## Timing
- All outputs reset to 0: wren, wr_adr, rst_trig, trig_adr, start_adr, busy, done.
- rst is asynchronous. Mid-capture it forces IDLE and zero outputs immediately, and the capture is lost.
- arm sampled at edge N: wren = 1 and wr_adr = 0 from cycle N+1.
- Trigger accepted at edge T: rst_trig = 1 in cycle T+1 only, and trig_adr/start_adr are valid from T+1.
- Last write at edge L: done = 1 and wren = 0 from cycle L+1.
- rd_ack at edge A: in auto mode wren = 1 again from A+1, and no cycle is spent in IDLE.

## Test plan
Bench uses DEPTH = 8, ADR_W = 3.
- Zero pre-trigger: pre_len = 0, arm, trig in the 4th ARMED cycle -> trig_adr = 3.
  - 8 writes total after the trigger, at addresses 3,4,5,6,7,0,1,2.
  - done next cycle; start_adr = 3; rst_trig high exactly one cycle.
- Trigger held from arm: pre_len = 3, trig held high from arm -> PRE writes 0,1,2 with no trigger.
  - Trigger taken on the first ARMED write: trig_adr = 3.
  - POST writes 4..7; start_adr = 0.
- Circular wrap: pre_len = 3, trig after 10 ARMED writes (addresses 3..7,0..4) -> trigger on address 5, trig_adr = 5, start_adr = 2.
  - POST writes 6,7,0,1; wr_adr = 2 at done.
- Clamp: pre_len = 9 -> clamped to 7; trigger on address 7 goes straight from ARMED to DONE, start_adr = 0.
- Mode handling: rd_ack in DONE with mode = 1 -> PRE next cycle, wr_adr = 0.
  - Same with mode = 0 -> IDLE.
  - arm during POST and rd_ack during ARMED have no effect.
- Reset mid-capture: rst in the middle of POST -> all outputs 0 without waiting for a clock edge.
  - After release, no writes occur until arm.

Source files
------------

// File: rtl/trig_capture_adr_gen.sv
// -----------------------------------------------------------------------------
// trig_capture_adr_gen
//
// Write-address generator for a triggered sample-capture RAM built as a
// circular buffer of DEPTH words. A capture writes pre_len samples before the
// trigger, the trigger sample itself, and enough samples after it to fill the
// buffer exactly once. It then reports where the oldest sample is.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   arm_i        start a capture (only in IDLE)
//   trig_i       trigger request level (only sampled in ARMED)
//   mode_i       0 = single shot, 1 = auto re-arm after rd_ack_i
//   pre_len_i    pre-trigger sample count, latched at arm
//   rd_ack_i     reader finished with the buffer (only in DONE)
//   wren_o       RAM write enable
//   wr_adr_o     RAM write address
//   rst_trig_o   one-cycle pulse clearing the upstream trigger latch
//   trig_adr_o   address holding the trigger sample
//   start_adr_o  address of the oldest captured sample
//   busy_o       capture in progress (PRE, ARMED, POST)
//   done_o       capture complete, waiting for rd_ack_i
// -----------------------------------------------------------------------------
module trig_capture_adr_gen #(
  parameter int DEPTH = 640,
  parameter int ADR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic             mode_i,
  input  logic [ADR_W-1:0] pre_len_i,
  input  logic             rd_ack_i,
  output logic             wren_o,
  output logic [ADR_W-1:0] wr_adr_o,
  output logic             rst_trig_o,
  output logic [ADR_W-1:0] trig_adr_o,
  output logic [ADR_W-1:0] start_adr_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(DEPTH - 1);
  localparam logic [ADR_W-1:0] ONE       = ADR_W'(1);
  localparam logic [ADR_W:0]   DEPTH_EXT = (ADR_W + 1)'(DEPTH);

  // Circular increment; the wrap is explicit so non power-of-two depths work.
  function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] a);
    return (a == LAST_ADR) ? {ADR_W{1'b0}} : a + ONE;
  endfunction

  // (t - p) mod DEPTH, done one bit wider so DEPTH = 2^ADR_W cannot overflow.
  function automatic logic [ADR_W-1:0] adr_sub(input logic [ADR_W-1:0] t,
                                               input logic [ADR_W-1:0] p);
    logic [ADR_W:0] wrapped;
    wrapped = {1'b0, t} + DEPTH_EXT - {1'b0, p};
    return (t >= p) ? (t - p) : wrapped[ADR_W-1:0];
  endfunction

  state_t           state_q,     state_d;
  logic [ADR_W-1:0] wr_adr_q,    wr_adr_d;
  logic [ADR_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic [ADR_W-1:0] post_cnt_q,  post_cnt_d;
  logic [ADR_W-1:0] pre_len_q,   pre_len_d;
  logic [ADR_W-1:0] trig_adr_q,  trig_adr_d;
  logic [ADR_W-1:0] start_adr_q, start_adr_d;
  logic             rst_trig_q,  rst_trig_d;
  logic             wren_q,      wren_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             launch;
  logic [ADR_W-1:0] pre_len_clamped;

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    wr_adr_d    = wr_adr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    pre_len_d   = pre_len_q;
    trig_adr_d  = trig_adr_q;
    start_adr_d = start_adr_q;
    rst_trig_d  = 1'b0;
    launch      = 1'b0;
    pre_len_clamped = (pre_len_i > LAST_ADR) ? LAST_ADR : pre_len_i;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        wr_adr_d  = adr_inc(wr_adr_q);
        pre_cnt_d = pre_cnt_q + ONE;
        // pre_len_q >= 1 whenever PRE is entered
        if (pre_cnt_q == pre_len_q - ONE) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_PRE;
        end
      end
      S_ARMED: begin
        wr_adr_d = adr_inc(wr_adr_q);
        if (trig_i) begin
          trig_adr_d  = wr_adr_q;
          start_adr_d = adr_sub(wr_adr_q, pre_len_q);
          post_cnt_d  = LAST_ADR - pre_len_q;
          rst_trig_d  = 1'b1;
          // A full pre-trigger window leaves nothing to write after the trigger.
          if (pre_len_q == LAST_ADR) begin
            state_d = S_DONE;
          end else begin
            state_d = S_POST;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_POST: begin
        wr_adr_d   = adr_inc(wr_adr_q);
        post_cnt_d = post_cnt_q - ONE;
        if (post_cnt_q == ONE) begin
          state_d = S_DONE;
        end else begin
          state_d = S_POST;
        end
      end
      S_DONE: begin
        if (rd_ack_i) begin
          if (mode_i) begin
            launch = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared start-of-capture action for arm in IDLE and auto re-arm in DONE.
    if (launch) begin
      wr_adr_d  = {ADR_W{1'b0}};
      pre_cnt_d = {ADR_W{1'b0}};
      pre_len_d = pre_len_clamped;
      if (pre_len_clamped == {ADR_W{1'b0}}) begin
        state_d = S_ARMED;
      end else begin
        state_d = S_PRE;
      end
    end else begin
      pre_len_d = pre_len_q;
    end

    // Status flags are registered copies of the next state decode.
    wren_d = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);
    busy_d = wren_d;
    done_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_adr_q    <= {ADR_W{1'b0}};
      pre_cnt_q   <= {ADR_W{1'b0}};
      post_cnt_q  <= {ADR_W{1'b0}};
      pre_len_q   <= {ADR_W{1'b0}};
      trig_adr_q  <= {ADR_W{1'b0}};
      start_adr_q <= {ADR_W{1'b0}};
      rst_trig_q  <= 1'b0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_adr_q    <= wr_adr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      pre_len_q   <= pre_len_d;
      trig_adr_q  <= trig_adr_d;
      start_adr_q <= start_adr_d;
      rst_trig_q  <= rst_trig_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wren_o      = wren_q;
  assign wr_adr_o    = wr_adr_q;
  assign rst_trig_o  = rst_trig_q;
  assign trig_adr_o  = trig_adr_q;
  assign start_adr_o = start_adr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_trig_capture_adr_gen.sv
// -----------------------------------------------------------------------------
// Testbench for trig_capture_adr_gen. Main instance: DEPTH = 8, ADR_W = 3.
// A second instance with DEPTH = 8, ADR_W = 4 lets pre_len exceed DEPTH-1 so
// the clamp can be exercised. Expected write sequences come from the rule that
// a capture writes addresses 0,1,2,... mod DEPTH, one per cycle, with the
// trigger on write number pre_len + (ARMED cycles before the trigger).
// -----------------------------------------------------------------------------
module tb_trig_capture_adr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trig = 1'b0;
  logic       mode = 1'b0;
  logic       rd_ack = 1'b0;
  logic [2:0] pre_len = 3'd0;
  logic [3:0] pre_len4 = 4'd0;

  logic       wren, rst_trig, busy, done;
  logic [2:0] wr_adr, trig_adr, start_adr;
  logic       c_wren, c_rst_trig, c_busy, c_done;
  logic [3:0] c_wr_adr, c_trig_adr, c_start_adr;

  int total = 0;
  int bad   = 0;

  // monitor record (appended only by the monitor)
  logic [2:0] wq[$];
  int         rt_total = 0;

  // observations from the last do_capture
  int         done_cyc;
  int         wbase;
  int         nwrites;
  int         rt_seen;
  logic [2:0] o_tadr, o_sadr, o_wadr;
  logic       o_wren, o_busy;

  trig_capture_adr_gen #(.DEPTH(8), .ADR_W(3)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .trig_i(trig), .mode_i(mode),
    .pre_len_i(pre_len), .rd_ack_i(rd_ack),
    .wren_o(wren), .wr_adr_o(wr_adr), .rst_trig_o(rst_trig),
    .trig_adr_o(trig_adr), .start_adr_o(start_adr),
    .busy_o(busy), .done_o(done)
  );

  trig_capture_adr_gen #(.DEPTH(8), .ADR_W(4)) dut_c (
    .clk(clk), .rst(rst), .arm_i(arm), .trig_i(trig), .mode_i(mode),
    .pre_len_i(pre_len4), .rd_ack_i(rd_ack),
    .wren_o(c_wren), .wr_adr_o(c_wr_adr), .rst_trig_o(c_rst_trig),
    .trig_adr_o(c_trig_adr), .start_adr_o(c_start_adr),
    .busy_o(c_busy), .done_o(c_done)
  );

  always #5 clk = ~clk;

  // Record every RAM write and every rst_trig cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (wren) wq.push_back(wr_adr);
    if (rst_trig) rt_total = rt_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arm = 1'b0; trig = 1'b0; rd_ack = 1'b0; mode = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives one capture (start via arm or via rd_ack in auto mode) and records
  // what happened. m = ARMED cycles without trigger before the trigger cycle.
  task automatic do_capture(input logic [2:0] pl, input int m, input bit hold,
                            input bit via_ack, input bit noise);
    int cyc;
    int mm;
    int rt0;
    mm = hold ? 0 : m;
    pre_len = pl;
    trig = hold;
    if (via_ack) begin
      mode = 1'b1; rd_ack = 1'b1;
    end else begin
      mode = 1'b0; arm = 1'b1;
    end
    @(posedge clk);
    wbase = wq.size();
    rt0 = rt_total;
    #1;
    arm = 1'b0; rd_ack = 1'b0; mode = 1'b0;
    cyc = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < mm + 40) begin
      if (!hold && cyc == int'(pl) + mm) trig = 1'b1;
      rd_ack = noise && (cyc == int'(pl));
      arm    = noise && (cyc == int'(pl) + mm + 1);
      tick();
      cyc++;
      if (done) done_cyc = cyc;
    end
    trig = 1'b0; arm = 1'b0; rd_ack = 1'b0;
    @(negedge clk);
    #1;
    nwrites = wq.size() - wbase;
    rt_seen = rt_total - rt0;
    o_tadr = trig_adr; o_sadr = start_adr; o_wadr = wr_adr;
    o_wren = wren; o_busy = busy;
  endtask

  task automatic test_reset();
    int w0;
    tick();
    tick();
    total++;
    if ({wren, wr_adr, rst_trig, trig_adr, start_adr, busy, done} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0",
               {wren, wr_adr, rst_trig, trig_adr, start_adr, busy, done});
    end
    total++;
    if ({c_wren, c_wr_adr, c_rst_trig, c_trig_adr, c_start_adr, c_busy, c_done} !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs_c: got %b want 0",
               {c_wren, c_wr_adr, c_rst_trig, c_trig_adr, c_start_adr, c_busy, c_done});
    end
    rst = 1'b0;
    w0 = wq.size();
    repeat (4) tick();
    total++;
    if (wq.size() != w0) begin
      bad++;
      $display("FAIL reset_no_writes: got %0d writes want 0", wq.size() - w0);
    end
  endtask

  task automatic test_zero_pre();
    int errs;
    do_reset();
    do_capture(3'd0, 3, 1'b0, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < nwrites; i++)
      if (wq[wbase + i] !== 3'(i % 8)) errs++;
    total++;
    if (nwrites != 11 || errs != 0) begin
      bad++;
      $display("FAIL zero_pre_writes: got %0d writes %0d bad addrs want 11 writes", nwrites, errs);
    end
    total++;
    if (o_tadr !== 3'd3) begin bad++; $display("FAIL zero_pre_trig_adr: got %0d want 3", o_tadr); end
    total++;
    if (o_sadr !== 3'd3) begin bad++; $display("FAIL zero_pre_start_adr: got %0d want 3", o_sadr); end
    total++;
    if (done_cyc != 11) begin bad++; $display("FAIL zero_pre_done_cycle: got %0d want 11", done_cyc); end
    total++;
    if (rt_seen != 1) begin bad++; $display("FAIL zero_pre_rst_trig: got %0d cycles want 1", rt_seen); end
    total++;
    if (o_wren !== 1'b0 || o_busy !== 1'b0 || o_wadr !== 3'd3) begin
      bad++;
      $display("FAIL zero_pre_done_state: got wren=%b busy=%b wr_adr=%0d want 0 0 3", o_wren, o_busy, o_wadr);
    end
  endtask

  task automatic test_trig_held();
    int errs;
    do_reset();
    do_capture(3'd3, 0, 1'b1, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < nwrites; i++)
      if (wq[wbase + i] !== 3'(i % 8)) errs++;
    total++;
    if (nwrites != 8 || errs != 0) begin
      bad++;
      $display("FAIL held_writes: got %0d writes %0d bad addrs want 8 writes", nwrites, errs);
    end
    total++;
    if (o_tadr !== 3'd3 || o_sadr !== 3'd0) begin
      bad++;
      $display("FAIL held_adrs: got trig=%0d start=%0d want 3 0", o_tadr, o_sadr);
    end
    total++;
    if (done_cyc != 8 || rt_seen != 1) begin
      bad++;
      $display("FAIL held_done: got done_cyc=%0d rst_trig=%0d want 8 1", done_cyc, rt_seen);
    end
  endtask

  task automatic test_wrap();
    int errs;
    do_reset();
    do_capture(3'd3, 10, 1'b0, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < nwrites; i++)
      if (wq[wbase + i] !== 3'(i % 8)) errs++;
    total++;
    if (nwrites != 18 || errs != 0) begin
      bad++;
      $display("FAIL wrap_writes: got %0d writes %0d bad addrs want 18 writes", nwrites, errs);
    end
    total++;
    if (o_tadr !== 3'd5 || o_sadr !== 3'd2 || o_wadr !== 3'd2) begin
      bad++;
      $display("FAIL wrap_adrs: got trig=%0d start=%0d wr=%0d want 5 2 2", o_tadr, o_sadr, o_wadr);
    end
  endtask

  task automatic test_clamp();
    int errs;
    do_reset();
    pre_len4 = 4'd9;
    pre_len  = 3'd1;
    trig = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    errs = 0;
    for (int c = 0; c < 8; c++) begin
      if (c_wren !== 1'b1 || c_wr_adr !== 4'(c)) errs++;
      tick();
    end
    trig = 1'b0;
    total++;
    if (errs != 0) begin bad++; $display("FAIL clamp_writes: got %0d bad cycles want 0", errs); end
    total++;
    if (c_done !== 1'b1 || c_wren !== 1'b0 || c_rst_trig !== 1'b1) begin
      bad++;
      $display("FAIL clamp_done: got done=%b wren=%b rst_trig=%b want 1 0 1", c_done, c_wren, c_rst_trig);
    end
    total++;
    if (c_trig_adr !== 4'd7 || c_start_adr !== 4'd0 || c_wr_adr !== 4'd0) begin
      bad++;
      $display("FAIL clamp_adrs: got trig=%0d start=%0d wr=%0d want 7 0 0", c_trig_adr, c_start_adr, c_wr_adr);
    end
  endtask

  task automatic test_mode();
    int errs;
    int n;
    do_reset();
    // rd_ack during ARMED and arm during POST must not disturb the capture
    do_capture(3'd2, 1, 1'b0, 1'b0, 1'b1);
    errs = 0;
    for (int i = 0; i < nwrites; i++)
      if (wq[wbase + i] !== 3'(i % 8)) errs++;
    total++;
    if (nwrites != 9 || errs != 0 || o_tadr !== 3'd3 || o_sadr !== 3'd1 || done_cyc != 9) begin
      bad++;
      $display("FAIL mode_ignored_inputs: got writes=%0d errs=%0d trig=%0d start=%0d done_cyc=%0d want 9 0 3 1 9",
               nwrites, errs, o_tadr, o_sadr, done_cyc);
    end
    // auto re-arm: straight back to writing from address 0
    mode = 1'b1; rd_ack = 1'b1; pre_len = 3'd2;
    tick();
    rd_ack = 1'b0;
    total++;
    if (wren !== 1'b1 || wr_adr !== 3'd0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mode_auto_rearm: got wren=%b wr_adr=%0d done=%b busy=%b want 1 0 0 1", wren, wr_adr, done, busy);
    end
    tick();
    total++;
    if (wr_adr !== 3'd1) begin bad++; $display("FAIL mode_auto_advance: got %0d want 1", wr_adr); end
    trig = 1'b1;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    trig = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL mode_auto_timeout: got done=%b want 1", done); end
    // single-shot: rd_ack returns to IDLE and nothing restarts
    mode = 1'b0; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || wren !== 1'b0) begin
      bad++;
      $display("FAIL mode_single_idle: got done=%b busy=%b wren=%b want 0 0 0", done, busy, wren);
    end
    mode = 1'b1; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0; mode = 1'b0;
    tick();
    total++;
    if (wren !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mode_ack_in_idle: got wren=%b busy=%b want 0 0", wren, busy);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset();
    pre_len = 3'd1; trig = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    trig = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({wren, wr_adr, rst_trig, trig_adr, start_adr, busy, done} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid_async: got %b want 0",
               {wren, wr_adr, rst_trig, trig_adr, start_adr, busy, done});
    end
    tick();
    rst = 1'b0;
    w0 = wq.size();
    repeat (4) tick();
    total++;
    if (wq.size() != w0 || wren !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got %0d writes wren=%b want 0 0", wq.size() - w0, wren);
    end
    pre_len = 3'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (wren !== 1'b1 || wr_adr !== 3'd0) begin
      bad++;
      $display("FAIL reset_mid_rearm: got wren=%b wr_adr=%0d want 1 0", wren, wr_adr);
    end
  endtask

  task automatic test_random();
    int errs;
    int m;
    bit in_done;
    bit via;
    logic [2:0] pl;
    do_reset();
    in_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      pl  = 3'($urandom_range(0, 7));
      m   = int'($urandom_range(0, 12));
      via = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !via) begin
        mode = 1'b0; rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || wren !== 1'b0) begin
          bad++;
          $display("FAIL rand_idle[%0d]: got done=%b busy=%b wren=%b want 0 0 0", k, done, busy, wren);
        end
      end
      do_capture(pl, m, 1'b0, via, ($urandom_range(0, 1) == 1));
      errs = 0;
      for (int i = 0; i < nwrites; i++)
        if (wq[wbase + i] !== 3'(i % 8)) errs++;
      total++;
      if (nwrites != m + 8 || errs != 0) begin
        bad++;
        $display("FAIL rand_writes[%0d]: pl=%0d m=%0d got %0d writes %0d bad want %0d",
                 k, pl, m, nwrites, errs, m + 8);
      end
      total++;
      if (o_tadr !== 3'((int'(pl) + m) % 8) || o_sadr !== 3'(m % 8) || o_wadr !== 3'(m % 8)) begin
        bad++;
        $display("FAIL rand_adrs[%0d]: pl=%0d m=%0d got trig=%0d start=%0d wr=%0d want %0d %0d %0d",
                 k, pl, m, o_tadr, o_sadr, o_wadr, (int'(pl) + m) % 8, m % 8, m % 8);
      end
      total++;
      if (done_cyc != m + 8 || rt_seen != 1 || o_wren !== 1'b0) begin
        bad++;
        $display("FAIL rand_done[%0d]: got done_cyc=%0d rst_trig=%0d wren=%b want %0d 1 0",
                 k, done_cyc, rt_seen, o_wren, m + 8);
      end
      in_done = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_zero_pre();
    test_trig_held();
    test_wrap();
    test_clamp();
    test_mode();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
